// File: rtl/pwm_duty_capture_if.sv
// Signal bundle between a PWM capture block (slave) and the logic that enables it and consumes its results (master).
interface pwm_duty_capture_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             pwm_in;
  logic [7:0]       duty_cycle;
  logic [CNT_W-1:0] period;
  logic             duty_valid;
  logic             signal_lost;
  logic             busy;

  modport master (
    output en, pwm_in,
    input  duty_cycle, period, duty_valid, signal_lost, busy
  );

  modport slave (
    input  en, pwm_in,
    output duty_cycle, period, duty_valid, signal_lost, busy
  );
endinterface

// File: rtl/pwm_duty_capture.sv
// Measures high time and period of an asynchronous PWM line and reports duty (0..100 %) and period in clk cycles.
// Optional glitch filter on the synchronized input: define PWM_GLITCH_FILTER_EN.
module pwm_duty_capture #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 60000,
  parameter int SYNC_STAGES = 2
`ifdef PWM_GLITCH_FILTER_EN
  ,
  parameter int FILT_LEN    = 4
`endif
) (
  input  logic              clk,
  input  logic              n_rst,
  pwm_duty_capture_if.slave bus
);

  localparam int               NUM_W  = CNT_W + 7;
  localparam logic [CNT_W-1:0] CNT_TO = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, MEAS_HIGH, MEAS_LOW} state_t;

  state_t                  state, state_nxt;
  logic [SYNC_STAGES-1:0]  sync_p0;
  logic                    s_p0, s_p1, s_d_p1, rise_p1, fall_p1;
  logic [CNT_W-1:0]        cnt, hi_lat, per_lat;
  logic                    to_done, to_fire, lat_hi, start_div;
  logic                    busy_r;
  logic [2:0]              iter;
  logic [NUM_W-1:0]        rem_p2, dsr_p2, rem_nxt_p2;
  logic [6:0]              quo_p2;
  logic signed [NUM_W:0]   trial_p2;
  logic                    ge_p2;
  logic [7:0]              quo_nxt_p2;
  logic [7:0]              duty_r;
  logic [CNT_W-1:0]        period_r;
  logic                    dv_r, lost_r;

  function automatic logic [7:0] sat_pct(input logic [7:0] q);
    return (q > 8'd100) ? 8'd100 : q;
  endfunction

  // Stage p0: input synchronizer
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) sync_p0 <= '0;
    else        sync_p0 <= {sync_p0[SYNC_STAGES-2:0], bus.pwm_in};
  end
  assign s_p0 = sync_p0[SYNC_STAGES-1];

  // Stage p1: optional glitch filter, then edge detection
`ifdef PWM_GLITCH_FILTER_EN
  localparam int FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  logic [FC_W-1:0] filt_cnt;
  logic            filt_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      filt_q   <= 1'b0;
      filt_cnt <= '0;
    end else if (s_p0 == filt_q) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FC_W'(FILT_LEN - 1)) begin
      filt_q   <= s_p0;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end
  assign s_p1 = filt_q;
`else
  assign s_p1 = s_p0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) s_d_p1 <= 1'b0;
    else        s_d_p1 <= s_p1;
  end
  assign rise_p1 = s_p1 & ~s_d_p1;
  assign fall_p1 = ~s_p1 & s_d_p1;

  // Cycle counter saturates at TIMEOUT; to_done keeps the timeout report to one pulse per stall
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt     <= '0;
      to_done <= 1'b0;
    end else begin
      to_done <= bus.en && (cnt == CNT_TO);
      if (!bus.en)             cnt <= '0;
      else if (rise_p1)        cnt <= CNT_W'(1);
      else if (cnt != CNT_TO)  cnt <= cnt + 1'b1;
    end
  end
  assign to_fire = bus.en && (cnt == CNT_TO) && !to_done;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    lat_hi    = 1'b0;
    start_div = 1'b0;
    if (!bus.en || to_fire) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:      if (rise_p1) state_nxt = MEAS_HIGH;
        MEAS_HIGH: if (fall_p1) begin
                     lat_hi    = 1'b1;
                     state_nxt = MEAS_LOW;
                   end
        MEAS_LOW:  if (rise_p1) begin
                     start_div = !busy_r;
                     state_nxt = MEAS_HIGH;
                   end
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // Stage p2: restoring divider, one quotient bit per cycle, MSB first
  assign trial_p2   = $signed({1'b0, rem_p2}) - $signed({1'b0, dsr_p2});
  assign ge_p2      = ~trial_p2[NUM_W];
  assign rem_nxt_p2 = ge_p2 ? trial_p2[NUM_W-1:0] : rem_p2;
  assign quo_nxt_p2 = {quo_p2, ge_p2};

  always_ff @(posedge clk) begin
    if (lat_hi) hi_lat <= cnt;
    if (start_div) begin
      per_lat <= cnt;
      rem_p2  <= NUM_W'(hi_lat) * NUM_W'(100);
      dsr_p2  <= {cnt, 7'b0};
    end else if (busy_r) begin
      rem_p2  <= rem_nxt_p2;
      dsr_p2  <= dsr_p2 >> 1;
      quo_p2  <= quo_nxt_p2[6:0];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy_r   <= 1'b0;
      iter     <= '0;
      dv_r     <= 1'b0;
      lost_r   <= 1'b0;
      duty_r   <= '0;
      period_r <= '0;
    end else begin
      dv_r <= 1'b0;
      if (!bus.en) begin
        busy_r <= 1'b0;
      end else if (to_fire) begin
        busy_r   <= 1'b0;
        dv_r     <= 1'b1;
        lost_r   <= 1'b1;
        duty_r   <= s_p1 ? 8'd100 : 8'd0;
        period_r <= '0;
      end else if (start_div) begin
        busy_r <= 1'b1;
        iter   <= '0;
      end else if (busy_r) begin
        iter <= iter + 1'b1;
        if (iter == 3'd7) begin
          busy_r   <= 1'b0;
          dv_r     <= 1'b1;
          lost_r   <= 1'b0;
          duty_r   <= sat_pct(quo_nxt_p2);
          period_r <= per_lat;
        end
      end
    end
  end

  assign bus.duty_cycle  = duty_r;
  assign bus.period      = period_r;
  assign bus.duty_valid  = dv_r;
  assign bus.signal_lost = lost_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Directed bench for pwm_duty_capture: expected results queued at stimulus time, popped on each duty_valid.
module tb_pwm_duty_capture;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 8000;
`ifdef PWM_GLITCH_FILTER_EN
  localparam int LAT = 15;
`else
  localparam int LAT = 11;
`endif

  typedef struct {
    int duty;
    int per;
    int lost;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst;
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pwm_duty_capture_if #(.CNT_W(CNT_W)) bus ();

  pwm_duty_capture #(
    .CNT_W      (CNT_W),
    .TIMEOUT    (TIMEOUT),
    .SYNC_STAGES(2)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    if (n_rst === 1'b1 && bus.duty_valid === 1'b1) begin
      exp_t e;
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_valid observed duty=%0d period=%0d lost=%0d expected no pulse",
               bus.duty_cycle, bus.period, bus.signal_lost);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("sb_duty",   32'(bus.duty_cycle),  32'(e.duty));
        check_eq("sb_period", 32'(bus.period),      32'(e.per));
        check_eq("sb_lost",   32'(bus.signal_lost), 32'(e.lost));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input int p, input int l, input int n);
    exp_t e;
    e.duty = d;
    e.per  = p;
    e.lost = l;
    repeat (n) sb.push_back(e);
  endtask

  task automatic pwm_seq(input int hi, input int per, input int n);
    for (int i = 0; i < n; i++) begin
      bus.pwm_in = 1'b1;
      cyc(hi);
      bus.pwm_in = 1'b0;
      cyc(per - hi);
    end
  endtask

  task automatic restart();
    bus.en     = 1'b0;
    bus.pwm_in = 1'b0;
    cyc(6);
    bus.en = 1'b1;
    cyc(2);
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      cyc(1);
      k++;
    end
    check_eq({tag, "_drain"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic check_outputs(input string tag, input int d, input int p, input int l);
    check_eq({tag, "_duty"},   32'(bus.duty_cycle),  32'(d));
    check_eq({tag, "_period"}, 32'(bus.period),      32'(p));
    check_eq({tag, "_lost"},   32'(bus.signal_lost), 32'(l));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    n_rst      = 1'b1;
    bus.en     = 1'b0;
    bus.pwm_in = 1'b0;
    #2;
    n_rst = 1'b0;
    cyc(3);
    check_outputs("rst", 0, 0, 0);
    check_eq("rst_valid", 32'(bus.duty_valid), 32'd0);
    check_eq("rst_busy",  32'(bus.busy),       32'd0);
    n_rst  = 1'b1;
    bus.en = 1'b1;
    cyc(3);

    // 25 % at period 1000; also measure closing-rise to duty_valid latency
    push(25, 1000, 0, 3);
    pwm_seq(250, 1000, 3);
    bus.pwm_in = 1'b1;
    lat = 0;
    while (bus.duty_valid !== 1'b1 && lat < 40) begin
      cyc(1);
      lat++;
    end
    check_eq("t1_latency", 32'(lat), 32'(LAT));
    cyc(5);
    drain("t1", 50);
    check_outputs("t1_hold", 25, 1000, 0);

    // Truncation: 277700/5556 = 49.98 -> 49
    restart();
    push(49, 5556, 0, 2);
    pwm_seq(2777, 5556, 2);
    bus.pwm_in = 1'b1;
    cyc(30);
    drain("t2a", 50);
    restart();
    push(99, 1000, 0, 2);
    pwm_seq(999, 1000, 2);
    bus.pwm_in = 1'b1;
    cyc(30);
    drain("t2b", 50);
    check_outputs("t2b_hold", 99, 1000, 0);

    // Stuck low, stuck high, then recovery at 30 %
    restart();
    push(0, 0, 1, 1);
    cyc(9000);
    drain("t3_low", 10);
    check_outputs("t3_low", 0, 0, 1);
    bus.pwm_in = 1'b1;
    push(100, 0, 1, 1);
    cyc(9000);
    drain("t3_high", 10);
    check_outputs("t3_high", 100, 0, 1);
    bus.pwm_in = 1'b0;
    cyc(100);
    push(30, 1000, 0, 2);
    pwm_seq(300, 1000, 2);
    bus.pwm_in = 1'b1;
    cyc(30);
    drain("t3_resume", 50);
    check_outputs("t3_resume", 30, 1000, 0);

    // 2-cycle low glitch 200 cycles into a 500-cycle high phase
    restart();
`ifdef PWM_GLITCH_FILTER_EN
    push(50, 1000, 0, 2);
`else
    repeat (2) begin
      push(99, 202, 0, 1);
      push(37, 798, 0, 1);
    end
`endif
    repeat (2) begin
      bus.pwm_in = 1'b1;
      cyc(200);
      bus.pwm_in = 1'b0;
      cyc(2);
      bus.pwm_in = 1'b1;
      cyc(298);
      bus.pwm_in = 1'b0;
      cyc(500);
    end
    bus.pwm_in = 1'b1;
    cyc(30);
    drain("t4", 50);

    // Reset while the divider is running
    restart();
    pwm_seq(250, 1000, 1);
    bus.pwm_in = 1'b1;
    lat = 0;
    while (bus.busy !== 1'b1 && lat < 20) begin
      cyc(1);
      lat++;
    end
    check_eq("t5_busy_seen", 32'(bus.busy), 32'd1);
    n_rst = 1'b0;
    cyc(3);
    check_outputs("t5_rst", 0, 0, 0);
    check_eq("t5_rst_busy", 32'(bus.busy), 32'd0);
    n_rst = 1'b1;
    cyc(20);
    check_outputs("t5_after", 0, 0, 0);

    // en dropped mid-period: outputs hold, no pulse
    restart();
    push(25, 1000, 0, 2);
    pwm_seq(250, 1000, 2);
    bus.pwm_in = 1'b1;
    cyc(20);
    drain("t5_en", 50);
    cyc(229);
    bus.pwm_in = 1'b0;
    cyc(300);
    bus.en = 1'b0;
    cyc(450);
    bus.pwm_in = 1'b1;
    cyc(30);
    check_outputs("t5_en_hold", 25, 1000, 0);
    check_eq("t5_en_busy", 32'(bus.busy), 32'd0);

    // Short periods: every other period overruns the divider
    restart();
    push(50, `ifdef PWM_GLITCH_FILTER_EN 8 `else 6 `endif, 0, 5);
`ifdef PWM_GLITCH_FILTER_EN
    pwm_seq(4, 8, 10);
`else
    pwm_seq(3, 6, 10);
`endif
    bus.pwm_in = 1'b1;
    cyc(30);
    drain("t6", 50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
